// File: rtl/mult_div_unit_if.sv
// Bus bundle for the iterative multiply/divide unit.
// Carries request, mthi/mtlo writes, status flags and the HI/LO results.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, inA, inB, hi_wen, lo_wen, wd,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, hi_wen, lo_wen, wd,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO registers.
// Ports: clock, reset (async active-low), bus (slave: start/op/inA/inB/mthi/mtlo in, busy/done/div_by_zero/hi/lo out).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   raw_q, raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d, dz_q, dz_d;

    logic               in_sgn, in_sa, in_sb;
    logic [WIDTH-1:0]   in_amag, in_bmag;
    logic               is_div, is_sgn, neg;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_sgn  = ~bus.op[0];
    assign in_sa   = in_sgn & bus.inA[WIDTH-1];
    assign in_sb   = in_sgn & bus.inB[WIDTH-1];
    assign in_amag = in_sa ? -bus.inA : bus.inA;
    assign in_bmag = in_sb ? -bus.inB : bus.inB;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign neg    = is_sgn & (sa_q ^ sb_q);

    // Multiply: acc = {partial, multiplier}; add at the top, shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, a_q} : '0);

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, b_q};
    assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, b_q})
                              : div_trial[WIDTH-1:0];

    assign prod_fix = neg ? -acc_q : acc_q;
    assign quo_fix  = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = (is_sgn & sa_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                      : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        raw_d   = raw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.hi_wen) hi_d = bus.wd;
                if (bus.lo_wen) lo_d = bus.wd;
                if (bus.start) begin
                    state_d = CALC;
                    op_d    = bus.op;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    a_d     = in_amag;
                    b_d     = in_bmag;
                    raw_d   = bus.inA;
                    acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, in_amag}
                                        : {{WIDTH{1'b0}}, in_bmag};
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                end
            end
            CALC: begin
                acc_d = is_div
                      ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                      : {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_q == '0) begin
                    // Divide by zero: quotient saturates, dividend passes through raw.
                    lo_d = '1;
                    hi_d = raw_q;
                    dz_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            raw_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            raw_q   <= raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Vector table plus scoreboard queue; hand sequences for busy/reset corners.
module tb_mult_div_unit;
    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one operation; interfere=1 pokes start/hi_wen while busy.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input logic edz,
                         input bit interfere);
        int   lat;
        int   bcnt;
        exp_t e;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.inA   = a;
        bus.inB   = b;
        exp_q.push_back('{hi: ehi, lo: elo, dz: edz});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.inA   = ~a;
        bus.inB   = ~b;
        chk("busy_after_accept", {31'b0, bus.busy}, 1);
        chk("dz_cleared", {31'b0, bus.div_by_zero}, 0);
        lat  = 0;
        bcnt = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.busy) bcnt++;
            if (interfere && lat == 5) begin
                bus.start  = 1'b1;
                bus.op     = 2'b01;
                bus.inA    = 32'h0000_0009;
                bus.inB    = 32'h0000_0009;
                bus.hi_wen = 1'b1;
                bus.lo_wen = 1'b1;
                bus.wd     = 32'h0000_1234;
            end
            if (interfere && lat == 8) begin
                bus.start  = 1'b0;
                bus.hi_wen = 1'b0;
                bus.lo_wen = 1'b0;
            end
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
        chk("latency", lat, 33);
        chk("busy_cycles", bcnt, 33);
        e = exp_q.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dz});
    endtask

    initial begin
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                         32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
                         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h0000_0002,
                         32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                         32'h0000_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{2'b01, 32'h0001_0000, 32'h0001_0000,
                         32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
                         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE,
                         32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{2'b11, 32'd100, 32'd7,
                         32'h0000_0002, 32'h0000_000E, 1'b0});
        vecs.push_back('{2'b11, 32'd5, 32'd0,
                         32'h0000_0005, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,
                         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b11, 32'd3, 32'd4,
                         32'h0000_0003, 32'h0000_0000, 1'b0});

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.inA    = '0;
        bus.inB    = '0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wd     = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_dz", {31'b0, bus.div_by_zero}, 0);
        @(negedge clock);
        reset = 1'b1;

        // Back-to-back: each op starts on the edge after the previous done.
        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0);

        // Start/hi_wen poked while busy must not disturb or queue anything.
        do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        chk("no_queued_start", {31'b0, bus.busy}, 0);
        chk("hold_lo", bus.lo, 32'd42);

        // mthi / mtlo in IDLE.
        @(negedge clock);
        bus.hi_wen = 1'b1;
        bus.wd     = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        bus.hi_wen = 1'b0;
        chk("mthi", bus.hi, 32'hA5A5_A5A5);
        chk("mthi_lo_kept", bus.lo, 32'd42);
        @(negedge clock);
        bus.lo_wen = 1'b1;
        bus.wd     = 32'h5A5A_0001;
        @(posedge clock);
        #1;
        bus.lo_wen = 1'b0;
        chk("mtlo", bus.lo, 32'h5A5A_0001);
        @(negedge clock);
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wd     = 32'h0BAD_F00D;
        @(posedge clock);
        #1;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        chk("mt_both_hi", bus.hi, 32'h0BAD_F00D);
        chk("mt_both_lo", bus.lo, 32'h0BAD_F00D);

        // Reset 10 cycles into a divide.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.inA   = 32'd1000;
        bus.inB   = 32'd3;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_done", {31'b0, bus.done}, 0);
        @(negedge clock);
        reset = 1'b1;
        do_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
